// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 16x16 multiplier (low half) that borrows an external Hack ALU for every sum.
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_prod,
  output logic        resp_zr,
  output logic        resp_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out
);
  typedef enum logic [2:0] {IDLE, TEST, ADD, DBL, DONE} state_t;
  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
  // The ALU is idle (constant-zero function) outside ADD and DBL.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    alu_x      = '0;
    alu_y      = '0;
    alu_ctl    = CTL_ZERO;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mcand_d  = req_a;
          mplier_d = req_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = TEST;
        end
      end
      TEST: state_d = (cnt_q == 5'd16 || (EARLY_EXIT && mplier_q == 16'd0)) ? DONE :
                      mplier_q[0] ? ADD : DBL;
      ADD: begin
        alu_x   = acc_q;
        alu_y   = mcand_q;
        alu_ctl = CTL_ADD;
        acc_d   = alu_out;
        state_d = DBL;
      end
      DBL: begin
        alu_x    = mcand_q;
        alu_y    = mcand_q;
        alu_ctl  = CTL_ADD;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        state_d  = TEST;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign resp_prod = acc_q;
  assign resp_zr   = (acc_q == 16'd0);
  assign resp_ng   = acc_q[15];
endmodule
